// File: rtl/top_arb.sv
// top_arb: two-level round-robin pixel-event arbiter for a DVS-style array.
// Grants one active pixel per cycle; emits {row, col, pol} for event packing.

package arbiter_pkg;
    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int POLARITY = 2;
    localparam int ROW_W    = $clog2(ROWS);
    localparam int COL_W    = $clog2(COLS);
    localparam int WIDTH    = ROW_W + COL_W + POLARITY;
endpackage

module top_arb
    import arbiter_pkg::*;
(
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [COLS-1:0][POLARITY-1:0]        req_i [ROWS],
    input  logic                                 enable_i,
    output logic [ROWS-1:0][COLS-1:0]            gnt_o,
    output logic [WIDTH-1:0]                     data_out_o
);

    logic [ROWS-1:0][COLS-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0]           data_q, data_d;
    logic [ROW_W-1:0]           row_ptr_q, row_ptr_d;
    logic [ROWS-1:0][COL_W-1:0] col_ptr_q, col_ptr_d;

    logic [ROWS-1:0][COLS-1:0]  act;
    logic [ROWS-1:0]            row_any;
    logic                       row_hit;
    logic [ROW_W-1:0]           row_sel;
    logic [ROW_W-1:0]           row_idx;
    logic                       col_hit;
    logic [COL_W-1:0]           col_sel;
    logic [COL_W-1:0]           col_idx;

    // Active pixels; last cycle's grant is masked since its requester is still clearing.
    always_comb begin
        act     = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                act[r][c] = (|req_i[r][c]) & ~gnt_q[r][c];
            end
            row_any[r] = |act[r];
        end
    end

    // Row pick: first row with an active pixel, searching upward from row_ptr.
    always_comb begin
        row_hit = 1'b0;
        row_sel = '0;
        row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            row_idx = ROW_W'((int'(row_ptr_q) + i) % ROWS);
            if (!row_hit && row_any[row_idx]) begin
                row_hit = 1'b1;
                row_sel = row_idx;
            end
        end
    end

    // Column pick inside the chosen row, searching upward from that row's pointer.
    always_comb begin
        col_hit = 1'b0;
        col_sel = '0;
        col_idx = '0;
        for (int j = 0; j < COLS; j++) begin
            col_idx = COL_W'((int'(col_ptr_q[row_sel]) + j) % COLS);
            if (!col_hit && act[row_sel][col_idx]) begin
                col_hit = 1'b1;
                col_sel = col_idx;
            end
        end
    end

    // Next state: grant and advance pointers, or drop grant and hold everything else.
    always_comb begin
        gnt_d     = '0;
        data_d    = data_q;
        row_ptr_d = row_ptr_q;
        col_ptr_d = col_ptr_q;
        if (enable_i && row_hit && col_hit) begin
            gnt_d[row_sel][col_sel] = 1'b1;
            data_d = {row_sel, col_sel, req_i[row_sel][col_sel]};
            row_ptr_d = ROW_W'((int'(row_sel) + 1) % ROWS);
            col_ptr_d[row_sel] = COL_W'((int'(col_sel) + 1) % COLS);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gnt_q     <= '0;
            data_q    <= '0;
            row_ptr_q <= '0;
            col_ptr_q <= '0;
        end else begin
            gnt_q     <= gnt_d;
            data_q    <= data_d;
            row_ptr_q <= row_ptr_d;
            col_ptr_q <= col_ptr_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign data_out_o = data_q;

endmodule

// File: tb/tb_top_arb.sv
// tb_top_arb: scoreboard bench for top_arb.
// A reference model predicts each cycle's grant/word; outputs are checked after the edge.

module tb_top_arb;
    import arbiter_pkg::*;

    logic                          clk_i = 1'b0;
    logic                          reset_i;
    logic                          enable_i;
    logic [COLS-1:0][POLARITY-1:0] req_i [ROWS];
    logic [ROWS-1:0][COLS-1:0]     gnt_o;
    logic [WIDTH-1:0]              data_out_o;

    typedef struct packed {
        logic [ROWS*COLS-1:0] gnt;
        logic [WIDTH-1:0]     data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int                        m_rp;
    int                        m_cp [ROWS];
    logic [ROWS-1:0][COLS-1:0] m_gnt;
    logic [WIDTH-1:0]          m_data;
    bit                        clr_on_gnt;
    int                        n_gnt;

    top_arb dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .enable_i   (enable_i),
        .gnt_o      (gnt_o),
        .data_out_o (data_out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        exp_t                      e;
        logic [ROWS-1:0][COLS-1:0] g;
        int                        r, c, rs, cs;
        bit                        found;
        g = '0;
        found = 0;
        rs = 0;
        cs = 0;
        if (reset_i) begin
            m_rp = 0;
            foreach (m_cp[i]) m_cp[i] = 0;
            m_data = '0;
        end else if (enable_i) begin
            for (int k = 0; k < ROWS; k++) begin
                r = (m_rp + k) % ROWS;
                for (int j = 0; j < COLS; j++) begin
                    c = (m_cp[r] + j) % COLS;
                    if (!found && req_i[r][c] != 0 && !m_gnt[r][c]) begin
                        found = 1;
                        rs = r;
                        cs = c;
                    end
                end
            end
            if (found) begin
                g[rs][cs] = 1'b1;
                m_data = {rs[ROW_W-1:0], cs[COL_W-1:0], req_i[rs][cs]};
                m_rp = (rs + 1) % ROWS;
                m_cp[rs] = (cs + 1) % COLS;
            end
        end
        m_gnt = g;
        e.gnt = g;
        e.data = m_data;
        sb_q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        predict();
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("gnt", 32'(gnt_o), 32'(e.gnt));
            check("data", 32'(data_out_o), 32'(e.data));
        end
        n_gnt += $countones(gnt_o);
        if (clr_on_gnt) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (m_gnt[r][c]) req_i[r][c] = '0;
        end
    endtask

    task automatic clear_req();
        for (int r = 0; r < ROWS; r++) req_i[r] = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    int n_act;
    int left;

    initial begin
        m_gnt = '0;
        m_data = '0;
        n_gnt = 0;
        clr_on_gnt = 0;
        enable_i = 1'b1;
        clear_req();
        req_i[1][2] = 2'b01;
        req_i[3][0] = 2'b10;

        // Reset with requests pending, then disabled with requests.
        do_reset();
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_data", 32'(data_out_o), 32'd0);
        enable_i = 1'b0;
        step();
        step();
        check("dis_gnt", 32'(gnt_o), 32'd0);

        // Single request.
        clear_req();
        enable_i = 1'b1;
        clr_on_gnt = 1;
        req_i[2][1] = 2'b01;
        step();
        check("single_gnt", 32'(gnt_o[2][1]), 32'd1);
        check("single_data", 32'(data_out_o), 32'h25);
        step();
        check("single_drop", 32'(gnt_o), 32'd0);
        check("single_hold", 32'(data_out_o), 32'h25);

        // Row round-robin.
        do_reset();
        req_i[0][0] = 2'b10;
        req_i[3][3] = 2'b01;
        step();
        check("rr0_data", 32'(data_out_o), 32'h02);
        step();
        check("rr1_data", 32'(data_out_o), 32'h3D);
        step();
        check("rr_idle", 32'(gnt_o), 32'd0);

        // Column round-robin within row 1.
        do_reset();
        req_i[1] = {2'b01, 2'b01, 2'b01, 2'b01};
        for (int c = 0; c < COLS; c++) begin
            step();
            check("col_1hot", 32'($countones(gnt_o)), 32'd1);
            check("col_data", 32'(data_out_o), 32'h11 + 32'(4 * c));
        end

        // Random requests with an enable drop.
        do_reset();
        n_act = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                req_i[r][c] = 2'($urandom_range(0, 2));
                if (req_i[r][c] != 0) n_act++;
            end
        n_gnt = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            enable_i = !(cyc == 3 || cyc == 4);
            step();
            if (!enable_i) check("dis_mid", 32'(gnt_o), 32'd0);
            check("rand_onehot", 32'($countones(gnt_o) <= 1), 32'd1);
        end
        enable_i = 1'b1;
        left = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (req_i[r][c] != 0) left++;
        check("rand_left", 32'(left), 32'd0);
        check("rand_ngnt", 32'(n_gnt), 32'(n_act));

        // Held request alternates due to masking.
        clr_on_gnt = 0;
        do_reset();
        req_i[0][2] = 2'b01;
        for (int i = 0; i < 6; i++) begin
            step();
            check("held", 32'(gnt_o[0][2]), 32'(i % 2 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
